// File: rtl/decode_stage.sv
// MIPS decode stage: decodes fetched words into a DEPTH-entry FIFO with load-use stall and halt tracking.
// Define DECODE_EXT_EN to add AND/OR/SLL/SRL/BNE decoding and their hazard sources.
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_dec_inst,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shamt,
  output logic [15:0]            out_imm,
  output logic [PC_W-1:0]        out_pc,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] INST_NOP   = 6'd0;
  localparam logic [5:0] INST_ADDU  = 6'd1;
  localparam logic [5:0] INST_SUBU  = 6'd2;
  localparam logic [5:0] INST_SLT   = 6'd3;
  localparam logic [5:0] INST_JR    = 6'd4;
  localparam logic [5:0] INST_LUI   = 6'd5;
  localparam logic [5:0] INST_ORI   = 6'd6;
  localparam logic [5:0] INST_LW    = 6'd7;
  localparam logic [5:0] INST_SW    = 6'd8;
  localparam logic [5:0] INST_BEQ   = 6'd9;
  localparam logic [5:0] INST_J     = 6'd10;
  localparam logic [5:0] INST_ADDI  = 6'd11;
  localparam logic [5:0] INST_ADDIU = 6'd12;
  localparam logic [5:0] INST_JAL   = 6'd13;
  localparam logic [5:0] INST_HLT   = 6'd14;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_HLT     = 6'h3F;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_SLT     = 6'h2A;

`ifdef DECODE_EXT_EN
  localparam logic [5:0] INST_AND   = 6'd15;
  localparam logic [5:0] INST_OR    = 6'd16;
  localparam logic [5:0] INST_SLL   = 6'd17;
  localparam logic [5:0] INST_SRL   = 6'd18;
  localparam logic [5:0] INST_BNE   = 6'd19;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
`endif

  typedef struct packed {
    logic [5:0]      dec;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        inEntry;
  entry_t        head;
  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          lwPend_q, lwPend_d;
  logic [4:0]    lwRt_q, lwRt_d;
  logic          halted_q, halted_d;
  logic [5:0]    opcode, funct, decInst;
  logic          full, empty, push, pop, stall, showHead;
  logic          headUsesRs, headUsesRt;

  assign opcode = in_inst[31:26];
  assign funct  = in_inst[5:0];

  // Guarded encodings fall back to NOP when their must-be-zero fields are not zero.
  always_comb begin
    decInst = INST_NOP;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU: if (in_inst[10:6] == 5'd0) decInst = INST_ADDU;
          FN_SUBU: if (in_inst[10:6] == 5'd0) decInst = INST_SUBU;
          FN_SLT:  if (in_inst[10:6] == 5'd0) decInst = INST_SLT;
          FN_JR:   if (in_inst[20:16] == 5'd0 && in_inst[15:11] == 5'd0) decInst = INST_JR;
`ifdef DECODE_EXT_EN
          FN_AND:  if (in_inst[10:6] == 5'd0) decInst = INST_AND;
          FN_OR:   if (in_inst[10:6] == 5'd0) decInst = INST_OR;
          FN_SLL:  if (in_inst[25:21] == 5'd0) decInst = INST_SLL;
          FN_SRL:  if (in_inst[25:21] == 5'd0) decInst = INST_SRL;
`endif
          default: decInst = INST_NOP;
        endcase
      end
      OP_LUI:   if (in_inst[25:21] == 5'd0) decInst = INST_LUI;
      OP_ORI:   decInst = INST_ORI;
      OP_LW:    decInst = INST_LW;
      OP_SW:    decInst = INST_SW;
      OP_BEQ:   decInst = INST_BEQ;
      OP_J:     decInst = INST_J;
      OP_ADDI:  decInst = INST_ADDI;
      OP_ADDIU: decInst = INST_ADDIU;
      OP_JAL:   decInst = INST_JAL;
      OP_HLT:   decInst = INST_HLT;
`ifdef DECODE_EXT_EN
      OP_BNE:   decInst = INST_BNE;
`endif
      default:  decInst = INST_NOP;
    endcase
  end

  always_comb begin
    inEntry       = '0;
    inEntry.dec   = decInst;
    inEntry.rs    = in_inst[25:21];
    inEntry.rt    = in_inst[20:16];
    inEntry.rd    = in_inst[15:11];
    inEntry.shamt = in_inst[10:6];
    inEntry.imm   = in_inst[15:0];
    inEntry.pc    = in_pc;
  end

  assign head  = mem_q[rdPtr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // Which register fields the head entry actually reads, for the load-use check.
  always_comb begin
    headUsesRs = 1'b0;
    headUsesRt = 1'b0;
    case (head.dec)
      INST_ADDU, INST_SUBU, INST_SLT, INST_SW, INST_BEQ: begin
        headUsesRs = 1'b1;
        headUsesRt = 1'b1;
      end
      INST_JR, INST_ORI, INST_LW, INST_ADDI, INST_ADDIU: headUsesRs = 1'b1;
`ifdef DECODE_EXT_EN
      INST_AND, INST_OR, INST_BNE: begin
        headUsesRs = 1'b1;
        headUsesRt = 1'b1;
      end
      INST_SLL, INST_SRL: headUsesRt = 1'b1;
`endif
      default: begin
        headUsesRs = 1'b0;
        headUsesRt = 1'b0;
      end
    endcase
  end

  assign stall = lwPend_q && (lwRt_q != 5'd0) &&
                 ((headUsesRs && head.rs == lwRt_q) || (headUsesRt && head.rt == lwRt_q));

  assign in_ready  = !rst && !full && !halted_q && !flush;
  assign out_valid = !rst && !empty && !stall;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    lwPend_d = 1'b0;
    lwRt_d   = lwRt_q;
    halted_d = halted_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop) begin
        rdPtr_d = rdPtr_q + 1'b1;
        if (head.dec == INST_LW) begin
          lwPend_d = 1'b1;
          lwRt_d   = head.rt;
        end
        if (head.dec == INST_HLT) halted_d = 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      lwPend_q <= 1'b0;
      lwRt_q   <= 5'd0;
      halted_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      lwPend_q <= lwPend_d;
      lwRt_q   <= lwRt_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= inEntry;
  end

  // Stale storage is masked so an empty or resetting stage presents a clean NOP.
  assign showHead     = !rst && !empty;
  assign out_dec_inst = showHead ? head.dec   : INST_NOP;
  assign out_rs       = showHead ? head.rs    : 5'd0;
  assign out_rt       = showHead ? head.rt    : 5'd0;
  assign out_rd       = showHead ? head.rd    : 5'd0;
  assign out_shamt    = showHead ? head.shamt : 5'd0;
  assign out_imm      = showHead ? head.imm   : 16'd0;
  assign out_pc       = showHead ? head.pc    : '0;
  assign halted       = halted_q && !rst;
  assign count        = rst ? '0 : count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (DEPTH=2); expectations follow DECODE_EXT_EN when defined.
module tb_decode_stage;

  localparam int PC_W  = 32;
  localparam int DEPTH = 2;

  localparam logic [5:0] INST_NOP   = 6'd0;
  localparam logic [5:0] INST_ADDU  = 6'd1;
  localparam logic [5:0] INST_SUBU  = 6'd2;
  localparam logic [5:0] INST_SLT   = 6'd3;
  localparam logic [5:0] INST_JR    = 6'd4;
  localparam logic [5:0] INST_LUI   = 6'd5;
  localparam logic [5:0] INST_ORI   = 6'd6;
  localparam logic [5:0] INST_LW    = 6'd7;
  localparam logic [5:0] INST_SW    = 6'd8;
  localparam logic [5:0] INST_BEQ   = 6'd9;
  localparam logic [5:0] INST_J     = 6'd10;
  localparam logic [5:0] INST_ADDI  = 6'd11;
  localparam logic [5:0] INST_ADDIU = 6'd12;
  localparam logic [5:0] INST_JAL   = 6'd13;
  localparam logic [5:0] INST_HLT   = 6'd14;
`ifdef DECODE_EXT_EN
  localparam logic [5:0] INST_AND   = 6'd15;
  localparam logic [5:0] INST_OR    = 6'd16;
  localparam logic [5:0] INST_SLL   = 6'd17;
  localparam logic [5:0] INST_SRL   = 6'd18;
  localparam logic [5:0] INST_BNE   = 6'd19;
`endif

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            in_valid  = 1'b0;
  logic            flush     = 1'b0;
  logic            out_ready = 1'b0;
  logic [31:0]     in_inst   = 32'd0;
  logic [PC_W-1:0] in_pc     = '0;
  logic            in_ready, out_valid, halted;
  logic [5:0]      out_dec_inst;
  logic [4:0]      out_rs, out_rt, out_rd, out_shamt;
  logic [15:0]     out_imm;
  logic [PC_W-1:0] out_pc;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  logic [31:0] tblInst [15] = '{32'h00221823, 32'h0022182A, 32'h00221861, 32'h03E00008,
                                32'h03E00808, 32'h3C011234, 32'h34221234, 32'hAC220004,
                                32'h10220003, 32'h08000010, 32'h0C000010, 32'h20220005,
                                32'h24220005, 32'h1C000000, 32'h8C220000};
  logic [5:0]  tblExp  [15] = '{INST_SUBU, INST_SLT, INST_NOP, INST_JR,
                                INST_NOP, INST_LUI, INST_ORI, INST_SW,
                                INST_BEQ, INST_J, INST_JAL, INST_ADDI,
                                INST_ADDIU, INST_NOP, INST_LW};

  logic [31:0] extInst [6] = '{32'h00021080, 32'h00021082, 32'h00221824,
                               32'h00221825, 32'h14220003, 32'h00221864};
`ifdef DECODE_EXT_EN
  logic [5:0]  extExp  [6] = '{INST_SLL, INST_SRL, INST_AND, INST_OR, INST_BNE, INST_NOP};
  logic        extBubble   = 1'b1;
`else
  logic [5:0]  extExp  [6] = '{INST_NOP, INST_NOP, INST_NOP, INST_NOP, INST_NOP, INST_NOP};
  logic        extBubble   = 1'b0;
`endif

  logic [31:0] luLoad [3] = '{32'h8C220000, 32'h8C220000, 32'h8C200000};
  logic [31:0] luUse  [3] = '{32'h00422021, 32'h00632021, 32'h00001021};
  logic        luBub  [3] = '{1'b1, 1'b0, 1'b0};
  logic [4:0]  luRd   [3] = '{5'd4, 5'd4, 5'd2};

  always #5 clk = ~clk;

  decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_dec_inst(out_dec_inst),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_pc(out_pc), .halted(halted), .count(count)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL rst_halted: got %b want 0", halted); end
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d want 0", count); end
    checks++; if (out_dec_inst !== INST_NOP) begin errors++; $display("[TB] FAIL rst_dec: got %0d want %0d", out_dec_inst, INST_NOP); end
    checks++; if (out_rs !== 5'd0 || out_imm !== 16'd0 || out_pc !== '0) begin errors++; $display("[TB] FAIL rst_fields: rs=%0d imm=%h pc=%h want 0", out_rs, out_imm, out_pc); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00221821; in_pc = 32'h40;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addu_valid: got %b want 1", out_valid); end
    checks++; if (out_dec_inst !== INST_ADDU) begin errors++; $display("[TB] FAIL addu_dec: got %0d want %0d", out_dec_inst, INST_ADDU); end
    checks++; if (out_rs !== 5'd1 || out_rt !== 5'd2 || out_rd !== 5'd3) begin errors++; $display("[TB] FAIL addu_regs: got %0d/%0d/%0d want 1/2/3", out_rs, out_rt, out_rd); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("[TB] FAIL addu_pc: got %h want 40", out_pc); end
    checks++; if (count !== 2'd1) begin errors++; $display("[TB] FAIL addu_count1: got %0d want 1", count); end
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL addu_count0: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addu_drained: got %b want 0", out_valid); end
    in_valid = 1'b1; in_inst = 32'h3C211234;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_dec_inst !== INST_NOP) begin errors++; $display("[TB] FAIL lui_rs_dec: got %0d want %0d", out_dec_inst, INST_NOP); end
    checks++; if (out_imm !== 16'h1234) begin errors++; $display("[TB] FAIL lui_rs_imm: got %h want 1234", out_imm); end
    @(negedge clk);
  endtask

  task automatic test_decode_table();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_inst = tblInst[i];
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_dec_inst !== tblExp[i]) begin errors++; $display("[TB] FAIL decode_%0d (%h): got valid=%b dec=%0d want valid=1 dec=%0d", i, tblInst[i], out_valid, out_dec_inst, tblExp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_ext();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_inst = extInst[i];
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_dec_inst !== extExp[i]) begin errors++; $display("[TB] FAIL ext_dec_%0d (%h): got %0d want %0d", i, extInst[i], out_dec_inst, extExp[i]); end
      if (i == 0) begin
        checks++; if (out_rt !== 5'd2 || out_rd !== 5'd2 || out_shamt !== 5'd2) begin errors++; $display("[TB] FAIL ext_sll_fields: got rt=%0d rd=%0d sh=%0d want 2/2/2", out_rt, out_rd, out_shamt); end
      end
      @(negedge clk);
    end
    // SLL reads rt only when the extension is compiled in
    in_valid = 1'b1; in_inst = 32'h8C220000;
    @(negedge clk);
    in_inst = 32'h00021080;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== !extBubble) begin errors++; $display("[TB] FAIL ext_sll_hazard: got valid=%b want %b", out_valid, !extBubble); end
    repeat (2) @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL ext_hazard_drain: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b2b [4] = '{32'h00221821, 32'h00222021, 32'h00222821, 32'h00223021};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = b2b[i]; in_pc = 32'h100 + 32'(4 * i);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'(3 + i)) begin errors++; $display("[TB] FAIL b2b_%0d: got valid=%b rd=%0d want 1/%0d", i, out_valid, out_rd, 3 + i); end
      checks++; if (count !== 2'd1 || out_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("[TB] FAIL b2b_cnt_pc_%0d: got count=%0d pc=%h want 1/%h", i, count, out_pc, 32'h100 + 32'(4 * i)); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL b2b_drain: got %0d want 0", count); end
  endtask

  task automatic test_load_use();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_inst = luLoad[k];
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_dec_inst !== INST_LW) begin errors++; $display("[TB] FAIL lu_%0d_lw: got valid=%b dec=%0d want 1/%0d", k, out_valid, out_dec_inst, INST_LW); end
      in_inst = luUse[k];
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== !luBub[k]) begin errors++; $display("[TB] FAIL lu_%0d_bubble: got valid=%b want %b", k, out_valid, !luBub[k]); end
      if (luBub[k]) begin
        checks++; if (count !== 2'd1) begin errors++; $display("[TB] FAIL lu_%0d_held: got count=%0d want 1", k, count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL lu_%0d_single: got valid=%b want 1", k, out_valid); end
      end
      checks++; if (out_dec_inst !== INST_ADDU || out_rd !== luRd[k]) begin errors++; $display("[TB] FAIL lu_%0d_use: got dec=%0d rd=%0d want %0d/%0d", k, out_dec_inst, out_rd, INST_ADDU, luRd[k]); end
      @(negedge clk);
      checks++; if (count !== 2'd0) begin errors++; $display("[TB] FAIL lu_%0d_drain: got %0d want 0", k, count); end
    end
  endtask

  task automatic test_full_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h34221234; in_pc = 32'h200;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_rdy0: got %b want 1", in_ready); end
    @(negedge clk);
    in_inst = 32'hAC220004;
    checks++; if (in_ready !== 1'b1 || count !== 2'd1) begin errors++; $display("[TB] FAIL full_one: got rdy=%b count=%0d want 1/1", in_ready, count); end
    @(negedge clk);
    in_inst = 32'h00221821;
    checks++; if (in_ready !== 1'b0 || count !== 2'd2) begin errors++; $display("[TB] FAIL full_two: got rdy=%b count=%0d want 0/2", in_ready, count); end
    @(negedge clk);
    checks++; if (count !== 2'd2) begin errors++; $display("[TB] FAIL full_third_refused: got %0d want 2", count); end
    checks++; if (out_valid !== 1'b1 || out_dec_inst !== INST_ORI || out_imm !== 16'h1234) begin errors++; $display("[TB] FAIL full_hold: got valid=%b dec=%0d imm=%h want 1/%0d/1234", out_valid, out_dec_inst, out_imm, INST_ORI); end
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty: got count=%0d valid=%b want 0/0", count, out_valid); end
    in_valid = 1'b1; in_inst = 32'h34221234; flush = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_rdy: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop_push: got count=%0d valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00221821;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 2'd2) begin errors++; $display("[TB] FAIL mid_fill: got %0d want 2", count); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst: got count=%0d valid=%b rdy=%b want 0/0/0", count, out_valid, in_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || count !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after: got rdy=%b count=%0d valid=%b want 1/0/0", in_ready, count, out_valid); end
  endtask

  task automatic test_halt();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFC000000;
    @(negedge clk);
    checks++; if (out_dec_inst !== INST_HLT || halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hlt_head: got dec=%0d halted=%b rdy=%b want %0d/0/1", out_dec_inst, halted, in_ready, INST_HLT); end
    in_inst = 32'h00221821;
    @(negedge clk);
    in_inst = 32'h34221234;
    checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hlt_set: got halted=%b rdy=%b want 1/0", halted, in_ready); end
    checks++; if (out_valid !== 1'b1 || out_dec_inst !== INST_ADDU) begin errors++; $display("[TB] FAIL hlt_drain: got valid=%b dec=%0d want 1/%0d", out_valid, out_dec_inst, INST_ADDU); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (count !== 2'd0 || halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hlt_sticky: got count=%0d halted=%b rdy=%b want 0/1/0", count, halted, in_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL hlt_rst: got %b want 0", halted); end
    @(negedge clk);
    checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hlt_after_rst: got halted=%b rdy=%b want 0/1", halted, in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode_table();
    test_ext();
    test_back_to_back();
    test_load_use();
    test_full_flush();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
